// File: rtl/rram_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : rram_fsm_if
// Description : Array-side bus between rram_fsm and the RRAM macro/sense amps.
// Revision    : 1.0 - initial release
// ============================================================================
interface rram_fsm_if #(
    parameter int ADDR_W = 16,
    parameter int WIDTH  = 48,
    parameter int DAC_W  = 8
);
    logic [ADDR_W-1:0] rram_addr;
    logic              we;
    logic              set_rst;
    logic              wl_en;
    logic              bl_en;
    logic              sl_en;
    logic [WIDTH-1:0]  di;
    logic [DAC_W-1:0]  wl_dac_config;
    logic [DAC_W-1:0]  bsl_dac_config;
    logic              sa_en;
    logic              sa_rdy;
    logic [WIDTH-1:0]  sa_do;

    modport master (
        output rram_addr, we, set_rst, wl_en, bl_en, sl_en, di,
               wl_dac_config, bsl_dac_config, sa_en,
        input  sa_rdy, sa_do
    );

    modport slave (
        input  rram_addr, we, set_rst, wl_en, bl_en, sl_en, di,
               wl_dac_config, bsl_dac_config, sa_en,
        output sa_rdy, sa_do
    );
endinterface
`default_nettype wire

// File: rtl/rram_fsm.sv
`default_nettype none
// ============================================================================
// Module      : rram_fsm
// Description : RRAM word read / SET / RESET / WRITE controller with iterative
//               pulse-verify and ramped DAC levels. Define RRAM_FSM_DIAG_EN to
//               enable the failed-word counter on diag_bits.
// Revision    : 1.0 - initial release
// ============================================================================
module rram_fsm #(
    parameter int ADDR_W = 16,
    parameter int WIDTH  = 48,
    parameter int DAC_W  = 8,
    parameter int PW_W   = 8
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              fsm_go,
    input  logic [1:0]        opcode,
    input  logic              use_multi_addrs,
    input  logic [ADDR_W-1:0] address_start,
    input  logic [ADDR_W-1:0] address_stop,
    input  logic [ADDR_W-1:0] address_step,
    input  logic [7:0]        max_attempts,
    input  logic [DAC_W-1:0]  wl_dac_set_lvl_start,
    input  logic [DAC_W-1:0]  wl_dac_set_lvl_step,
    input  logic [DAC_W-1:0]  wl_dac_set_lvl_stop,
    input  logic [DAC_W-1:0]  sl_dac_rst_lvl_start,
    input  logic [DAC_W-1:0]  sl_dac_rst_lvl_step,
    input  logic [DAC_W-1:0]  sl_dac_rst_lvl_stop,
    input  logic [PW_W-1:0]   pw_set_cycle,
    input  logic [PW_W-1:0]   pw_rst_cycle,
    input  logic [WIDTH-1:0]  write_data_bits,
    output logic              rram_busy,
    output logic [WIDTH-1:0]  read_data_bits,
    output logic [2:0]        fsm_bits,
    output logic [15:0]       diag_bits,
    rram_fsm_if.master        arr
);
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_READ      = 3'd1;
    localparam logic [2:0] c_VERIFY    = 3'd2;
    localparam logic [2:0] c_SET_PULSE = 3'd3;
    localparam logic [2:0] c_RST_PULSE = 3'd4;
    localparam logic [2:0] c_NEXT      = 3'd5;
    localparam logic [2:0] c_DONE      = 3'd6;

    localparam logic [1:0] c_OP_READ  = 2'd0;
    localparam logic [1:0] c_OP_SET   = 2'd1;
    localparam logic [1:0] c_OP_RESET = 2'd2;
    localparam int         c_RAMP_W   = DAC_W + 8;

    logic [2:0]        r_state, w_next;
    logic [1:0]        r_op;
    logic              r_multi;
    logic [ADDR_W-1:0] r_addr, r_stop, r_step;
    logic [7:0]        r_max, r_attempt;
    logic [DAC_W-1:0]  r_set_start, r_set_step, r_set_stop;
    logic [DAC_W-1:0]  r_rst_start, r_rst_step, r_rst_stop;
    logic [PW_W-1:0]   r_pw_set, r_pw_rst, r_pw_cnt;
    logic [WIDTH-1:0]  r_wdata, r_need_set, r_need_rst, r_rdata, r_di;
    logic              r_busy, r_we, r_set_rst, r_wl_en, r_bl_en, r_sl_en, r_sa_en;
    logic [DAC_W-1:0]  r_wl_dac, r_bsl_dac;

    logic [WIDTH-1:0]    w_target, w_need_set, w_need_rst, w_di_set, w_di_rst;
    logic [ADDR_W:0]     w_next_addr;
    logic                w_adv, w_go, w_verify_done, w_match, w_exhausted;
    logic [c_RAMP_W-1:0] w_set_raw, w_rst_raw;
    logic [DAC_W-1:0]    w_set_lvl, w_rst_lvl;
    logic [PW_W-1:0]     w_pw_set_ld, w_pw_rst_ld;

    always_comb begin
        w_target = '0;
        case (r_op)
            c_OP_SET:   w_target = '1;
            c_OP_RESET: w_target = '0;
            c_OP_READ:  w_target = '0;
            default:    w_target = r_wdata;
        endcase
    end

    assign w_need_set    = w_target & ~arr.sa_do;
    assign w_need_rst    = ~w_target & arr.sa_do;
    assign w_match       = (w_need_set == '0) && (w_need_rst == '0);
    assign w_exhausted   = (r_attempt == r_max);
    assign w_go          = (r_state == c_IDLE) && fsm_go;
    assign w_verify_done = (r_state == c_VERIFY) && arr.sa_rdy;

    // Pulse masks come straight from the sense result when entering from VERIFY.
    assign w_di_set = (r_state == c_VERIFY) ? w_need_set : r_need_set;
    assign w_di_rst = (r_state == c_VERIFY) ? w_need_rst : r_need_rst;

    // Ramp is wide enough that start + 255*step cannot wrap before clamping.
    assign w_set_raw = {8'd0, r_set_start} + ({{DAC_W{1'b0}}, r_attempt} * {8'd0, r_set_step});
    assign w_rst_raw = {8'd0, r_rst_start} + ({{DAC_W{1'b0}}, r_attempt} * {8'd0, r_rst_step});
    assign w_set_lvl = (w_set_raw > {8'd0, r_set_stop}) ? r_set_stop : w_set_raw[DAC_W-1:0];
    assign w_rst_lvl = (w_rst_raw > {8'd0, r_rst_stop}) ? r_rst_stop : w_rst_raw[DAC_W-1:0];

    assign w_pw_set_ld = (r_pw_set == '0) ? '0 : r_pw_set - PW_W'(1);
    assign w_pw_rst_ld = (r_pw_rst == '0) ? '0 : r_pw_rst - PW_W'(1);

    assign w_next_addr = {1'b0, r_addr} + {1'b0, r_step};
    assign w_adv       = r_multi && (r_step != '0) && (w_next_addr <= {1'b0, r_stop});

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (fsm_go) w_next = (opcode == c_OP_READ) ? c_READ : c_VERIFY;
            c_READ:      if (arr.sa_rdy) w_next = c_NEXT;
            c_VERIFY: begin
                if (arr.sa_rdy) begin
                    if (w_match || w_exhausted) w_next = c_NEXT;
                    else if (w_need_set != '0)  w_next = c_SET_PULSE;
                    else                        w_next = c_RST_PULSE;
                end
            end
            c_SET_PULSE: if (r_pw_cnt == '0) w_next = (r_need_rst != '0) ? c_RST_PULSE : c_VERIFY;
            c_RST_PULSE: if (r_pw_cnt == '0) w_next = c_VERIFY;
            c_NEXT:      w_next = w_adv ? ((r_op == c_OP_READ) ? c_READ : c_VERIFY) : c_DONE;
            c_DONE:      w_next = c_IDLE;
            default:     w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_op        <= '0;
            r_multi     <= 1'b0;
            r_addr      <= '0;
            r_stop      <= '0;
            r_step      <= '0;
            r_max       <= '0;
            r_attempt   <= '0;
            r_set_start <= '0;
            r_set_step  <= '0;
            r_set_stop  <= '0;
            r_rst_start <= '0;
            r_rst_step  <= '0;
            r_rst_stop  <= '0;
            r_pw_set    <= '0;
            r_pw_rst    <= '0;
            r_pw_cnt    <= '0;
            r_wdata     <= '0;
            r_need_set  <= '0;
            r_need_rst  <= '0;
            r_rdata     <= '0;
            r_di        <= '0;
            r_busy      <= 1'b0;
            r_we        <= 1'b0;
            r_set_rst   <= 1'b0;
            r_wl_en     <= 1'b0;
            r_bl_en     <= 1'b0;
            r_sl_en     <= 1'b0;
            r_sa_en     <= 1'b0;
            r_wl_dac    <= '0;
            r_bsl_dac   <= '0;
        end else begin
            r_state   <= w_next;
            // Outputs are registered from the next state so they switch only on entry/exit.
            r_busy    <= (w_next != c_IDLE);
            r_sa_en   <= (w_next == c_READ) || (w_next == c_VERIFY);
            r_we      <= (w_next == c_SET_PULSE) || (w_next == c_RST_PULSE);
            r_set_rst <= (w_next == c_SET_PULSE);
            r_wl_en   <= (w_next == c_SET_PULSE) || (w_next == c_RST_PULSE);
            r_bl_en   <= (w_next == c_SET_PULSE);
            r_sl_en   <= (w_next == c_RST_PULSE);
            r_di      <= (w_next == c_SET_PULSE) ? w_di_set :
                         (w_next == c_RST_PULSE) ? w_di_rst : '0;
            r_wl_dac  <= (w_next == c_SET_PULSE) ? w_set_lvl : '0;
            r_bsl_dac <= (w_next == c_RST_PULSE) ? w_rst_lvl : '0;

            if (w_go) begin
                r_op        <= opcode;
                r_multi     <= use_multi_addrs;
                r_addr      <= address_start;
                r_stop      <= address_stop;
                r_step      <= address_step;
                r_max       <= max_attempts;
                r_attempt   <= '0;
                r_set_start <= wl_dac_set_lvl_start;
                r_set_step  <= wl_dac_set_lvl_step;
                r_set_stop  <= wl_dac_set_lvl_stop;
                r_rst_start <= sl_dac_rst_lvl_start;
                r_rst_step  <= sl_dac_rst_lvl_step;
                r_rst_stop  <= sl_dac_rst_lvl_stop;
                r_pw_set    <= pw_set_cycle;
                r_pw_rst    <= pw_rst_cycle;
                r_wdata     <= write_data_bits;
            end

            if (w_verify_done) begin
                r_need_set <= w_need_set;
                r_need_rst <= w_need_rst;
            end

            if ((r_state == c_READ) && arr.sa_rdy) r_rdata <= arr.sa_do;

            if ((w_next != r_state) && (w_next == c_SET_PULSE))      r_pw_cnt <= w_pw_set_ld;
            else if ((w_next != r_state) && (w_next == c_RST_PULSE)) r_pw_cnt <= w_pw_rst_ld;
            else if (r_pw_cnt != '0)                                 r_pw_cnt <= r_pw_cnt - PW_W'(1);

            if (r_state == c_NEXT) begin
                r_attempt <= '0;
                if (w_adv) r_addr <= w_next_addr[ADDR_W-1:0];
            end else if (((r_state == c_SET_PULSE) || (r_state == c_RST_PULSE)) && (w_next == c_VERIFY)) begin
                r_attempt <= r_attempt + 8'd1;
            end
        end
    end

`ifdef RRAM_FSM_DIAG_EN
    logic [15:0] r_diag;
    logic        w_fail;

    assign w_fail = w_verify_done && !w_match && w_exhausted;

    always_ff @(posedge mclk) begin
        if (rst)                                r_diag <= '0;
        else if (w_go)                          r_diag <= '0;
        else if (w_fail && (r_diag != 16'hFFFF)) r_diag <= r_diag + 16'd1;
    end

    assign diag_bits = r_diag;
`else
    assign diag_bits = 16'd0;
`endif

    assign rram_busy          = r_busy;
    assign read_data_bits     = r_rdata;
    assign fsm_bits           = r_state;
    assign arr.rram_addr      = r_addr;
    assign arr.we             = r_we;
    assign arr.set_rst        = r_set_rst;
    assign arr.wl_en          = r_wl_en;
    assign arr.bl_en          = r_bl_en;
    assign arr.sl_en          = r_sl_en;
    assign arr.di             = r_di;
    assign arr.wl_dac_config  = r_wl_dac;
    assign arr.bsl_dac_config = r_bsl_dac;
    assign arr.sa_en          = r_sa_en;
endmodule
`default_nettype wire

// File: tb/tb_rram_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_rram_fsm
// Description : Directed bench for rram_fsm with a one-word behavioural array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rram_fsm;
    localparam int ADDR_W = 16;
    localparam int WIDTH  = 48;
    localparam int DAC_W  = 8;
    localparam int PW_W   = 8;
`ifdef RRAM_FSM_DIAG_EN
    localparam logic [15:0] c_DIAG_EXP = 16'd1;
`else
    localparam logic [15:0] c_DIAG_EXP = 16'd0;
`endif

    logic              mclk = 1'b0;
    logic              rst = 1'b1;
    logic              fsm_go = 1'b0;
    logic [1:0]        opcode = '0;
    logic              use_multi_addrs = 1'b0;
    logic [ADDR_W-1:0] address_start = '0, address_stop = '0, address_step = '0;
    logic [7:0]        max_attempts = '0;
    logic [DAC_W-1:0]  wl_start = '0, wl_step = '0, wl_stop = '0;
    logic [DAC_W-1:0]  sl_start = '0, sl_step = '0, sl_stop = '0;
    logic [PW_W-1:0]   pw_set_cycle = '0, pw_rst_cycle = '0;
    logic [WIDTH-1:0]  write_data_bits = '0;
    logic              rram_busy;
    logic [WIDTH-1:0]  read_data_bits;
    logic [2:0]        fsm_bits;
    logic [15:0]       diag_bits;

    rram_fsm_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .DAC_W(DAC_W)) arr ();

    rram_fsm #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .DAC_W(DAC_W), .PW_W(PW_W)) dut (
        .mclk                 (mclk),
        .rst                  (rst),
        .fsm_go               (fsm_go),
        .opcode               (opcode),
        .use_multi_addrs      (use_multi_addrs),
        .address_start        (address_start),
        .address_stop         (address_stop),
        .address_step         (address_step),
        .max_attempts         (max_attempts),
        .wl_dac_set_lvl_start (wl_start),
        .wl_dac_set_lvl_step  (wl_step),
        .wl_dac_set_lvl_stop  (wl_stop),
        .sl_dac_rst_lvl_start (sl_start),
        .sl_dac_rst_lvl_step  (sl_step),
        .sl_dac_rst_lvl_stop  (sl_stop),
        .pw_set_cycle         (pw_set_cycle),
        .pw_rst_cycle         (pw_rst_cycle),
        .write_data_bits      (write_data_bits),
        .rram_busy            (rram_busy),
        .read_data_bits       (read_data_bits),
        .fsm_bits             (fsm_bits),
        .diag_bits            (diag_bits),
        .arr                  (arr)
    );

    always #5 mclk = ~mclk;

    // Array model: one stored word (cells in 'stuck' never switch); sensed value is word ^ address.
    logic [WIDTH-1:0]  mem_word = '0;
    logic [WIDTH-1:0]  stuck = '0;
    logic              prev_we = 1'b0, prev_sr = 1'b0;
    int                p_n = 0, s_n = 0;
    logic              p_set [16];
    logic [WIDTH-1:0]  p_di  [16];
    logic [DAC_W-1:0]  p_lvl [16];
    int                p_len [16];
    logic [ADDR_W-1:0] s_addr[16];

    initial begin
        arr.sa_rdy = 1'b0;
        arr.sa_do  = '0;
    end

    always @(negedge mclk) begin
        if (arr.we) begin
            if (!prev_we || (arr.set_rst != prev_sr)) begin
                if (p_n < 16) begin
                    p_set[p_n] = arr.set_rst;
                    p_di[p_n]  = arr.di;
                    p_lvl[p_n] = arr.set_rst ? arr.wl_dac_config : arr.bsl_dac_config;
                    p_len[p_n] = 0;
                end
                p_n++;
            end
            if ((p_n > 0) && (p_n <= 16)) p_len[p_n-1]++;
            if (arr.set_rst) mem_word = mem_word | (arr.di & ~stuck);
            else             mem_word = mem_word & ~(arr.di & ~stuck);
        end
        prev_we = arr.we;
        prev_sr = arr.set_rst;
        if (arr.sa_en) begin
            if (s_n < 16) s_addr[s_n] = arr.rram_addr;
            s_n++;
        end
        arr.sa_rdy = arr.sa_en;
        arr.sa_do  = mem_word ^ {{(WIDTH-ADDR_W){1'b0}}, arr.rram_addr};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic run_op(input string tag);
        int n;
        n   = 0;
        p_n = 0;
        s_n = 0;
        fsm_go = 1'b1;
        cyc(1);
        fsm_go = 1'b0;
        check({tag, "_busy"}, rram_busy, 1);
        while ((fsm_bits != 3'd6) && (n < 2000)) begin
            cyc(1);
            n++;
        end
        check({tag, "_done_reached"}, (n < 2000), 1);
        cyc(1);
        check({tag, "_idle"}, {rram_busy, fsm_bits}, 4'b0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset with go held high
        rst = 1'b1;
        fsm_go = 1'b1;
        opcode = 2'd3;
        cyc(3);
        check("rst_state", fsm_bits, 3'd0);
        check("rst_busy", rram_busy, 0);
        check("rst_lines", {arr.we, arr.wl_en, arr.bl_en, arr.sl_en, arr.sa_en}, 5'b0);
        check("rst_rdata", read_data_bits, 0);
        check("rst_diag", diag_bits, 0);
        check("rst_addr", arr.rram_addr, 0);
        rst = 1'b0;
        fsm_go = 1'b0;
        cyc(2);

        // Single READ at address 5: stored A0 ^ addr 5 senses as A5
        opcode = 2'd0;
        use_multi_addrs = 1'b0;
        address_start = 16'd5;
        address_stop = 16'd5;
        address_step = 16'd1;
        mem_word = 48'hA0;
        run_op("read1");
        check("read1_data", read_data_bits, 48'hA5);
        check("read1_nsense", s_n, 1);
        check("read1_addr", s_addr[0], 16'd5);

        // Multi READ 0..10 step 4
        use_multi_addrs = 1'b1;
        address_start = 16'd0;
        address_stop = 16'd10;
        address_step = 16'd4;
        mem_word = 48'h1234_5600;
        run_op("multi");
        check("multi_nsense", s_n, 3);
        check("multi_a0", s_addr[0], 16'd0);
        check("multi_a1", s_addr[1], 16'd4);
        check("multi_a2", s_addr[2], 16'd8);
        check("multi_data", read_data_bits, 48'h1234_5608);

        // start > stop: only the start address
        address_start = 16'd9;
        address_stop = 16'd3;
        run_op("rev");
        check("rev_nsense", s_n, 1);
        check("rev_addr", s_addr[0], 16'd9);
        check("rev_data", read_data_bits, 48'h1234_5609);

        // SET-all on an all-0 word
        use_multi_addrs = 1'b0;
        address_start = 16'd0;
        address_stop = 16'd0;
        opcode = 2'd1;
        max_attempts = 8'd3;
        pw_set_cycle = 8'd3;
        wl_start = 8'd7;
        wl_step = 8'd5;
        wl_stop = 8'd200;
        mem_word = '0;
        run_op("set");
        check("set_npulse", p_n, 1);
        check("set_kind", p_set[0], 1);
        check("set_di", p_di[0], 48'hFFFF_FFFF_FFFF);
        check("set_len", p_len[0], 3);
        check("set_lvl", p_lvl[0], 8'd7);
        check("set_diag", diag_bits, 0);
        check("set_word", mem_word, 48'hFFFF_FFFF_FFFF);

        // WRITE F0 over 0F: SET then RESET inside one attempt
        opcode = 2'd3;
        write_data_bits = 48'hF0;
        pw_set_cycle = 8'd2;
        pw_rst_cycle = 8'd0;
        sl_start = 8'd9;
        sl_step = 8'd3;
        sl_stop = 8'd50;
        mem_word = 48'h0F;
        run_op("wr");
        check("wr_npulse", p_n, 2);
        check("wr_p0", {p_set[0], p_di[0], p_lvl[0]}, {1'b1, 48'hF0, 8'd7});
        check("wr_p0_len", p_len[0], 2);
        check("wr_p1", {p_set[1], p_di[1], p_lvl[1]}, {1'b0, 48'h0F, 8'd9});
        check("wr_p1_len", p_len[1], 1);
        check("wr_word", mem_word, 48'hF0);

        // RESET-all
        opcode = 2'd2;
        pw_rst_cycle = 8'd2;
        sl_start = 8'd30;
        sl_step = 8'd1;
        sl_stop = 8'd40;
        mem_word = 48'h3C;
        run_op("rs");
        check("rs_npulse", p_n, 1);
        check("rs_p0", {p_set[0], p_di[0], p_lvl[0]}, {1'b0, 48'h3C, 8'd30});
        check("rs_len", p_len[0], 2);
        check("rs_word", mem_word, 48'h0);

        // Stuck cells: ramp 0,10,20 then clamp at 25, word reported failed
        opcode = 2'd1;
        max_attempts = 8'd4;
        pw_set_cycle = 8'd1;
        wl_start = 8'd0;
        wl_step = 8'd10;
        wl_stop = 8'd25;
        mem_word = '0;
        stuck = '1;
        run_op("stk");
        check("stk_npulse", p_n, 4);
        check("stk_lvl0", p_lvl[0], 8'd0);
        check("stk_lvl1", p_lvl[1], 8'd10);
        check("stk_lvl2", p_lvl[2], 8'd20);
        check("stk_lvl3", p_lvl[3], 8'd25);
        check("stk_diag", diag_bits, c_DIAG_EXP);

        // Reset in the middle of a long SET pulse
        pw_set_cycle = 8'd20;
        fsm_go = 1'b1;
        cyc(1);
        fsm_go = 1'b0;
        n = 0;
        while ((fsm_bits != 3'd3) && (n < 100)) begin
            cyc(1);
            n++;
        end
        check("mid_in_pulse", {fsm_bits, arr.we}, {3'd3, 1'b1});
        rst = 1'b1;
        cyc(1);
        check("mid_we", arr.we, 0);
        check("mid_state", fsm_bits, 3'd0);
        check("mid_busy_di", {rram_busy, arr.di}, 49'd0);
        check("mid_diag", diag_bits, 0);
        rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
